// File: rtl/pds_pkg.sv
// Shared definitions for pattern_detect_sched: per-channel "101" context
// encoding and the single-step context transition / match function.
package pds_pkg;

  // Prefix of "101" seen so far on one channel.
  typedef enum logic [1:0] {
    CTX_IDLE  = 2'd0,  // no useful prefix
    CTX_GOT1  = 2'd1,  // "1"
    CTX_GOT10 = 2'd2   // "10"
  } ctx_e;

  typedef struct packed {
    ctx_e next;
    logic match;
  } ctx_step_t;

  // Advance one context by one received bit. Match flags the bit that
  // completes "101"; landing in GOT1 keeps overlapping patterns alive.
  function automatic ctx_step_t ctx_step(input ctx_e cur, input logic b);
    ctx_step_t r;
    r.match = 1'b0;
    case (cur)
      CTX_IDLE:  r.next = b ? CTX_GOT1 : CTX_IDLE;
      CTX_GOT1:  r.next = b ? CTX_GOT1 : CTX_GOT10;
      CTX_GOT10: begin
        r.next  = b ? CTX_GOT1 : CTX_IDLE;
        r.match = b;
      end
      default:   r.next = CTX_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pds_rr_arbiter.sv
// Round-robin one-hot grant: first requesting channel at or above the
// pointer, wrapping from N-1 to 0. Purely combinational.
module pds_rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] pointer,
  input  logic             en,
  output logic [N-1:0]     grant
);

  logic found;
  int   idx;

  // Scan N slots starting at the pointer and grant the first requester.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(pointer) + i;
      if (idx >= N) idx = idx - N;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pattern_detect_sched.sv
// pattern_detect_sched: round-robin scheduler over NUM_CH serial
// requesters, each with a private "101" detector context. A detection is
// reported one cycle after the completing bit is accepted.
// Optional build macro PDS_COUNT_EN adds saturating per-channel match
// counters readable through cnt_sel/cnt_data.
module pattern_detect_sched
  import pds_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  localparam int PTR_W = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clr,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_bit,
  output logic [NUM_CH-1:0] ch_ready,
  output logic              det_valid,
  output logic [PTR_W-1:0]  det_ch
`ifdef PDS_COUNT_EN
  ,
  input  logic [PTR_W-1:0]  cnt_sel,
  output logic [CNT_W-1:0]  cnt_data
`endif
);

  if (NUM_CH < 2 || NUM_CH > 8 || CNT_W < 1) begin : g_bad_params
    $error("pattern_detect_sched: NUM_CH must be 2..8 and CNT_W >= 1");
  end

  ctx_e             ctx_q [NUM_CH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             det_valid_q;
  logic [PTR_W-1:0] det_ch_q;

  logic             xfer;
  logic [PTR_W-1:0] xfer_idx;
  ctx_step_t        step;
  logic             match;

  // Clear wins over enable: no grant, hence no transfer, while clr is high.
  pds_rr_arbiter #(
    .N     (NUM_CH),
    .PTR_W (PTR_W)
  ) u_arb (
    .req     (ch_valid),
    .pointer (ptr_q),
    .en      (enable & ~clr),
    .grant   (ch_ready)
  );

  // Decode the granted channel, step its context and form the next pointer.
  always_comb begin
    xfer     = |ch_ready;
    xfer_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_ready[k]) xfer_idx = PTR_W'(k);
    end
    step  = ctx_step(ctx_q[xfer_idx], ch_bit[xfer_idx]);
    match = xfer & step.match;
    if (!xfer)
      ptr_d = ptr_q;
    else if (xfer_idx == PTR_W'(NUM_CH - 1))
      ptr_d = '0;
    else
      ptr_d = xfer_idx + PTR_W'(1);
  end

  // Contexts, pointer and detection report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the context array is reset element by element because a
      // stale prefix after reset would produce a false detection.
      for (int k = 0; k < NUM_CH; k++) ctx_q[k] <= CTX_IDLE;
      ptr_q       <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
    end else if (clr) begin
      for (int k = 0; k < NUM_CH; k++) ctx_q[k] <= CTX_IDLE;
      ptr_q       <= '0;
      det_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      if (xfer) ctx_q[xfer_idx] <= step.next;
      ptr_q       <= ptr_d;
      det_valid_q <= match;
      if (match) det_ch_q <= xfer_idx;
    end
  end

  assign det_valid = det_valid_q;
  assign det_ch    = det_ch_q;

`ifdef PDS_COUNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_CH];

  // Saturating per-channel match counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else if (match && (cnt_q[xfer_idx] != '1)) begin
      cnt_q[xfer_idx] <= cnt_q[xfer_idx] + CNT_W'(1);
    end
  end

  // Counter read port; selects past the last channel read as zero.
  always_comb begin
    cnt_data = '0;
    if (int'(cnt_sel) < NUM_CH) cnt_data = cnt_q[cnt_sel];
  end
`endif

endmodule

// File: tb/tb_pattern_detect_sched.sv
// Self-checking bench for pattern_detect_sched (NUM_CH=4, CNT_W=2).
// Per-channel bit queues act as requesters that hold until granted; an
// independent history-based model predicts grants and detections, and
// predicted detections are queued and popped when the DUT reports them.
module tb_pattern_detect_sched;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 2;
  localparam int PTR_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset, enable, clr;
  logic [NUM_CH-1:0] ch_valid, ch_bit, ch_ready;
  logic              det_valid;
  logic [PTR_W-1:0]  det_ch;
`ifdef PDS_COUNT_EN
  logic [PTR_W-1:0]  cnt_sel;
  logic [CNT_W-1:0]  cnt_data;
`endif

  always #5 clk = ~clk;

  pattern_detect_sched #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .clr       (clr),
    .ch_valid  (ch_valid),
    .ch_bit    (ch_bit),
    .ch_ready  (ch_ready),
    .det_valid (det_valid),
    .det_ch    (det_ch)
`ifdef PDS_COUNT_EN
    ,
    .cnt_sel   (cnt_sel),
    .cnt_data  (cnt_data)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester queues and reference model state.
  bit         bitq  [NUM_CH][$];
  int         ptr_m;
  logic [1:0] h_m   [NUM_CH];   // last two accepted bits, newest in [0]
  int         len_m [NUM_CH];   // accepted bits since clear, capped at 2
  int         cnt_m [NUM_CH];
  int         exp_q [$];        // scoreboard of expected det_ch values
  int         rd_sel = 0;

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < NUM_CH; k++) s += bitq[k].size();
    return s;
  endfunction

  task automatic model_clear();
    ptr_m = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      h_m[k] = 2'b00; len_m[k] = 0; cnt_m[k] = 0;
    end
  endtask

  // One clock: drive, check grant, predict, clock, check outputs.
  // Entered and left just after a falling edge.
  task automatic cycle();
    logic [NUM_CH-1:0] exp_rdy;
    int g, c;
    bit b;
    logic m;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_valid[k] = (bitq[k].size() > 0);
      ch_bit[k]   = (bitq[k].size() > 0) ? bitq[k][0] : 1'b0;
    end
    #1;
    exp_rdy = '0;
    g = -1;
    if (enable && !clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        c = (ptr_m + i) % NUM_CH;
        if (g < 0 && ch_valid[c]) g = c;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("ch_ready", ch_ready, exp_rdy);
    m = 1'b0;
    if (clr) begin
      model_clear();
    end else if (g >= 0) begin
      b = bitq[g].pop_front();
      m = b && (len_m[g] >= 2) && (h_m[g] == 2'b10);
      h_m[g] = {h_m[g][0], b};
      if (len_m[g] < 2) len_m[g]++;
      ptr_m = (g + 1) % NUM_CH;
      if (m) begin
        exp_q.push_back(g);
        if (cnt_m[g] < CNT_MAX) cnt_m[g]++;
      end
    end
    @(posedge clk);
    #1;
    check("det_valid", det_valid, m);
    if (m && exp_q.size() > 0) check("det_ch", det_ch, exp_q.pop_front());
`ifdef PDS_COUNT_EN
    rd_sel  = (rd_sel + 1) % NUM_CH;
    cnt_sel = PTR_W'(rd_sel);
    #1;
    check("cnt_data", cnt_data, cnt_m[rd_sel]);
`endif
    @(negedge clk);
  endtask

  task automatic run(input int max_cycles);
    int n = 0;
    while (pending() > 0 && n < max_cycles) begin
      cycle();
      n++;
    end
    check("drain_left", pending(), 0);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  // Reset asserted between clock edges, then released on a falling edge.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_det_valid", det_valid, 0);
    check("rst_det_ch", det_ch, 0);
    model_clear();
    exp_q.delete();
`ifdef PDS_COUNT_EN
    cnt_sel = PTR_W'(2);
    #1;
    check("rst_cnt_data", cnt_data, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; clr = 1'b0;
    ch_valid = '0; ch_bit = '0;
`ifdef PDS_COUNT_EN
    cnt_sel = '0;
`endif
    model_clear();
    @(negedge clk);
    check("init_det_valid", det_valid, 0);
    check("init_det_ch", det_ch, 0);
    check("init_ready", ch_ready, 0);
    reset = 1'b0;

    // Overlapping "10101" on channel 0 alone: two detections.
    bitq[0] = '{1, 0, 1, 0, 1};
    run(20);

    // All channels busy: grants rotate, one transfer each per 4 cycles.
    for (int k = 0; k < NUM_CH; k++) bitq[k] = '{1, 0, 1, 1, 0, 1, 0, 1};
    run(60);

    // Ch1 "10" stalls, ch2 "111" in between, then ch1 completes.
    clr_pulse();
    bitq[1] = '{1, 0};
    run(10);
    bitq[2] = '{1, 1, 1};
    run(10);
    bitq[1] = '{1};
    run(10);

    // Ch0 in GOT10 held off by enable=0, then matches on first transfer.
    clr_pulse();
    bitq[0] = '{1, 0};
    run(10);
    bitq[0].push_back(1);
    enable = 1'b0;
    repeat (5) cycle();
    enable = 1'b1;
    run(5);

    // clr in the cycle of a would-be match on ch3 cancels it.
    bitq[3] = '{1, 0};
    run(10);
    bitq[3] = '{1};
    clr_pulse();
    run(5);
    bitq[3] = '{0, 1};
    run(10);

    // Async reset discards the "10" prefix on ch0.
    bitq[0] = '{1, 0};
    run(10);
    async_reset();
    bitq[0] = '{1};
    run(5);
    bitq[0] = '{0, 1};
    run(10);

    // Five matches on ch2 saturate a 2-bit counter, then reset clears it.
    clr_pulse();
    bitq[2] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    run(30);
`ifdef PDS_COUNT_EN
    cnt_sel = PTR_W'(2);
    #1;
    check("cnt_sat", cnt_data, cnt_m[2]);
    #1;
    @(negedge clk);
`endif
    async_reset();

    // Random traffic with enable gaps and occasional clears.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (bitq[k].size() == 0 && $urandom_range(0, 2) != 0)
          bitq[k].push_back(bit'($urandom_range(0, 1)));
      end
      enable = ($urandom_range(0, 9) != 0);
      clr    = ($urandom_range(0, 49) == 0);
      cycle();
    end
    enable = 1'b1;
    clr    = 1'b0;
    run(50);
    check("sb_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_detect_sched.md
PATTERN_DETECT_SCHED -- requirements
Module: pattern_detect_sched

Interface
REQ-001 Parameter NUM_CH, default 4, number of serial requester channels (2..8).
REQ-002 Parameter CNT_W, default 8, width of each per-channel match counter.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  when 0, no channel is granted and all state holds.
REQ-006 clr  input  1  synchronous clear of contexts, counters, pointer and det_valid.
REQ-007 ch_valid  input  NUM_CH  per-channel bit-available request.
REQ-008 ch_bit  input  NUM_CH  per-channel serial data bit.
REQ-009 ch_ready  output  NUM_CH  one-hot grant; combinational from ch_valid, pointer, enable and clr.
REQ-010 det_valid  output  1  registered one-cycle pulse: "101" completed on det_ch.
REQ-011 det_ch  output  $clog2(NUM_CH)  channel index qualified by det_valid.
REQ-012 cnt_sel  input  $clog2(NUM_CH)  counter read select (PDS_COUNT_EN only).
REQ-013 cnt_data  output  CNT_W  combinational counter[cnt_sel] (PDS_COUNT_EN only).

Function
REQ-014 A transfer on channel k occurs in a cycle where ch_valid[k] and ch_ready[k] are both 1; at most one transfer occurs per cycle.
REQ-015 ch_ready is all-zero when enable=0, clr=1, or no ch_valid bit is set.
REQ-016 Otherwise ch_ready grants the first valid channel searching from pointer upward, wrapping from NUM_CH-1 to 0.
REQ-017 After a transfer on channel k, pointer becomes (k+1) mod NUM_CH; with no transfer, pointer holds.
REQ-018 Each channel has a private 2-bit context with states IDLE (no prefix), GOT1 ("1"), GOT10 ("10").
REQ-019 Transitions on transfer: IDLE: 1->GOT1, 0->IDLE; GOT1: 0->GOT10, 1->GOT1; GOT10: 1->GOT1, 0->IDLE.
REQ-020 A channel's context changes only on a transfer on that channel; all other contexts hold.
REQ-021 Match = transfer on channel k with context GOT10 and ch_bit[k]=1; overlapping patterns are detected ("10101" yields two matches).
REQ-022 On a match, det_valid=1 and det_ch=k in the next cycle (latency 1); otherwise det_valid=0 and det_ch holds its last value.
REQ-023 clr=1: next cycle all contexts IDLE, pointer 0, det_valid 0, counters 0; no transfer occurs in the clr cycle.
REQ-024 Requesters hold ch_valid and ch_bit stable until granted; the block does not buffer bits.

Reset
REQ-025 reset=1 asynchronously forces all contexts IDLE, pointer 0, det_valid 0, det_ch 0, counters 0.
REQ-026 Reset asserted mid-stream discards partial prefixes; the first match after release requires a full new "101" on that channel.

Configuration
REQ-027 With macro PDS_COUNT_EN defined: per-channel CNT_W-bit counters increment on each match on that channel, saturate at 2^CNT_W-1, and drive cnt_data.
REQ-028 cnt_sel >= NUM_CH reads cnt_data = 0.
REQ-029 Without PDS_COUNT_EN: no counters, no cnt_sel/cnt_data ports; all other behaviour is identical.

Structure
REQ-030 Package pds_pkg holds the context state encoding (IDLE=0, GOT1=1, GOT10=2) and the next-state/match function.
REQ-031 Round-robin grant logic is one sub-module, pds_rr_arbiter (inputs: req, pointer, en; output: one-hot grant).

Verification
REQ-032 Single channel 0 streams 1,0,1,0,1 with others idle -> det_valid pulses on cycles after bits 3 and 5, det_ch=0.
REQ-033 All 4 channels valid continuously -> grants rotate 0,1,2,3,0,...; each channel gets one transfer per 4 cycles.
REQ-034 Ch1 sends 1,0 then stalls; ch2 sends 1,1,1; ch1 then sends 1 -> exactly one match, det_ch=1, ch2 produces none.
REQ-035 Ch0 in GOT10, enable=0 for 5 cycles while ch_bit=1 -> no ready, no match; re-enable -> match on the first transfer.
REQ-036 clr asserted in the same cycle as a would-be match on ch3 -> no transfer, det_valid 0 next cycle, ch3 context IDLE.
REQ-037 PDS_COUNT_EN, CNT_W=2: 5 matches on ch2 -> cnt_sel=2 reads 3; async reset mid-cycle -> reads 0.
